// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter: FSM state
// encoding, default sizes and the rotating-priority pick function.
package add_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 16;
   localparam int MAXREQ    = 8;

   // Returns {found, idx}: the first set bit of valid[nreq-1:0] scanning
   // ptr, ptr+1, ... with wrap at nreq. Sized for the largest supported NREQ.
   function automatic logic [3:0] rr_pick(input logic [7:0] valid,
                                          input logic [2:0] ptr,
                                          input int         nreq);
      logic       found;
      logic [2:0] idx;
      int         j;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 0; k < MAXREQ; k++) begin
         j = (int'(ptr) + k) % nreq;
         if (k < nreq && !found && valid[j[2:0]]) begin
            found = 1'b1;
            idx   = j[2:0];
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/add_datapath.sv
// Purely combinational ripple-carry adder, carry-in tied low, built from a
// chain of full-adder cells.
module add_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_datapath
   import add_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic [WIDTH:0]   combine
);

   logic [WIDTH:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      add_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   assign carry   = c[WIDTH];
   assign combine = {c[WIDTH], sum};

endmodule

// File: rtl/add_rr_arbiter.sv
// Round-robin arbiter sharing one adder between NREQ requesters; one
// operation in flight at a time, IDLE -> CALC -> RESP.
//
// Handshakes: req_ready[i] is high only in IDLE, only for the round-robin
// winner, and only while rst is low; a request is taken on the edge where
// req_valid[i] && req_ready[i]. The response holds rsp_valid and all rsp_*
// data stable until the edge where rsp_valid && rsp_ready.
module add_rr_arbiter
   import add_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_carry,
   output logic [WIDTH:0]        rsp_combine,
   output logic                  busy,
   output state_e                dbg_state,
   output logic [IDW-1:0]        dbg_ptr
);

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] a_q, b_q;

   logic [7:0]       valid_ext;
   logic [2:0]       ptr_ext;
   logic [3:0]       pick;
   logic             found;
   logic [IDW-1:0]   win_idx;

   logic [WIDTH-1:0] dp_sum;
   logic             dp_carry;
   logic [WIDTH:0]   dp_combine;

   // Zero-extend to the fixed width the shared pick function expects.
   always_comb begin
      valid_ext = '0;
      valid_ext[NREQ-1:0] = req_valid;
      ptr_ext = '0;
      ptr_ext[IDW-1:0] = ptr_q;
   end

   assign pick    = rr_pick(valid_ext, ptr_ext, NREQ);
   assign found   = pick[3];
   assign win_idx = IDW'(pick[2:0]);

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = CALC;
               if (!rst) req_ready[win_idx] = 1'b1;
            end
         end
         CALC: state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_sum     <= '0;
         rsp_carry   <= 1'b0;
         rsp_combine <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (found) begin
                  a_q   <= req_a[win_idx*WIDTH +: WIDTH];
                  b_q   <= req_b[win_idx*WIDTH +: WIDTH];
                  id_q  <= win_idx;
                  // NREQ is a power of two, so the increment wraps naturally.
                  ptr_q <= win_idx + IDW'(1);
               end
            end
            CALC: begin
               rsp_sum     <= dp_sum;
               rsp_carry   <= dp_carry;
               rsp_combine <= dp_combine;
               rsp_id      <= id_q;
               rsp_valid   <= 1'b1;
            end
            RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   add_datapath #(.WIDTH(WIDTH)) u_dp (
      .a       (a_q),
      .b       (b_q),
      .sum     (dp_sum),
      .carry   (dp_carry),
      .combine (dp_combine)
   );

   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;
   assign dbg_ptr   = ptr_q;

endmodule
